// File: rtl/fuzzy_input_conditioner_if.sv
// Sample/crisp-input bundle between the plant front-end and the fuzzy core.
// The master side issues sample requests; the slave side is the conditioner.
interface fuzzy_input_conditioner_if #(
    parameter int DATA_W = 8
);
    logic              sample_req;
    logic [DATA_W-1:0] setpoint;
    logic [DATA_W-1:0] medida;
    logic [DATA_W-1:0] Entrada_01;
    logic [DATA_W-1:0] Entrada_02;
    logic              EN_REGRAS;
    logic              dado_valido;
    logic              busy;
    logic              sat_e;
    logic              sat_de;
    logic              req_perdido;

    modport master (
        output sample_req,
        output setpoint,
        output medida,
        input  Entrada_01,
        input  Entrada_02,
        input  EN_REGRAS,
        input  dado_valido,
        input  busy,
        input  sat_e,
        input  sat_de,
        input  req_perdido
    );

    modport slave (
        input  sample_req,
        input  setpoint,
        input  medida,
        output Entrada_01,
        output Entrada_02,
        output EN_REGRAS,
        output dado_valido,
        output busy,
        output sat_e,
        output sat_de,
        output req_perdido
    );
endinterface

// File: rtl/fuzzy_input_conditioner.sv
// Front-end for the type-2 fuzzy core: filters the measurement, forms error
// and change-of-error, and sequences EN_REGRAS for one inference per sample.
module fuzzy_input_conditioner #(
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int AVG_LOG2    = 2,
    parameter int E_SHIFT     = 0,
    parameter int DE_SHIFT    = 0
) (
    input logic                   clk_0,
    input logic                   Srst,
    fuzzy_input_conditioner_if.slave bus
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int E_W   = DATA_W + 1;
    localparam int DE_W  = DATA_W + 2;
    localparam int X_W   = DATA_W + 3;

    localparam logic [DATA_W-1:0] OFF =
        DATA_W'(1 << (DATA_W - 1));
    localparam logic signed [X_W-1:0] OFF_X =
        X_W'(1 << (DATA_W - 1));
    localparam logic signed [X_W-1:0] MAX_X =
        X_W'((1 << DATA_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        COMPUTE,
        HOLD,
        DONE
    } state_t;

    state_t                    state;
    logic [DATA_W-1:0]         win [N];
    logic [DATA_W-1:0]         sp_l;
    logic signed [E_W-1:0]     e_prev;
    logic                      prime;
    logic [7:0]                cnt;

    logic [SUM_W-1:0]          sum;
    logic [DATA_W-1:0]         avg;
    logic signed [E_W-1:0]     e;
    logic signed [DE_W-1:0]    de;
    logic signed [X_W-1:0]     e_x;
    logic signed [X_W-1:0]     de_x;
    logic [DATA_W-1:0]         e_out;
    logic [DATA_W-1:0]         de_out;
    logic                      e_clip;
    logic                      de_clip;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + SUM_W'(win[i]);
        end
        avg = DATA_W'(sum >> AVG_LOG2);

        e = $signed({1'b0, sp_l}) - $signed({1'b0, avg});

        // First sample after reset has no history, so no rate term.
        if (prime) begin
            de = '0;
        end else begin
            de = $signed({e[E_W-1], e})
               - $signed({e_prev[E_W-1], e_prev});
        end

        e_x  = ($signed({{(X_W-E_W){e[E_W-1]}}, e}) >>> E_SHIFT)
             + OFF_X;
        de_x = ($signed({{(X_W-DE_W){de[DE_W-1]}}, de}) >>> DE_SHIFT)
             + OFF_X;

        e_clip = 1'b1;
        if (e_x < 0) begin
            e_out = '0;
        end else if (e_x > MAX_X) begin
            e_out = '1;
        end else begin
            e_out  = e_x[DATA_W-1:0];
            e_clip = 1'b0;
        end

        de_clip = 1'b1;
        if (de_x < 0) begin
            de_out = '0;
        end else if (de_x > MAX_X) begin
            de_out = '1;
        end else begin
            de_out  = de_x[DATA_W-1:0];
            de_clip = 1'b0;
        end
    end

    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst) begin
            state           <= IDLE;
            sp_l            <= '0;
            e_prev          <= '0;
            prime           <= 1'b1;
            cnt             <= '0;
            bus.Entrada_01  <= OFF;
            bus.Entrada_02  <= OFF;
            bus.EN_REGRAS   <= 1'b0;
            bus.dado_valido <= 1'b0;
            bus.busy        <= 1'b0;
            bus.sat_e       <= 1'b0;
            bus.sat_de      <= 1'b0;
            bus.req_perdido <= 1'b0;
            for (int i = 0; i < N; i++) begin
                win[i] <= '0;
            end
        end else begin
            if (bus.sample_req && state != IDLE) begin
                bus.req_perdido <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (bus.sample_req) begin
                        state    <= CAPTURE;
                        bus.busy <= 1'b1;
                    end
                end

                CAPTURE: begin
                    sp_l <= bus.setpoint;
                    if (prime) begin
                        for (int i = 0; i < N; i++) begin
                            win[i] <= bus.medida;
                        end
                    end else begin
                        for (int i = 0; i < N - 1; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[N-1] <= bus.medida;
                    end
                    state <= COMPUTE;
                end

                COMPUTE: begin
                    bus.Entrada_01 <= e_out;
                    bus.Entrada_02 <= de_out;
                    bus.sat_e      <= e_clip;
                    bus.sat_de     <= de_clip;
                    e_prev         <= e;
                    prime          <= 1'b0;
                    cnt            <= 8'(HOLD_CYCLES);
                    bus.EN_REGRAS  <= 1'b1;
                    state          <= HOLD;
                end

                HOLD: begin
                    if (cnt == 8'd1) begin
                        bus.EN_REGRAS   <= 1'b0;
                        bus.dado_valido <= 1'b1;
                        state           <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                DONE: begin
                    bus.dado_valido <= 1'b0;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzy_input_conditioner.sv
// Randomized bench for fuzzy_input_conditioner against a queue-based
// model of the moving average, error and rate-of-error rules.
module tb_fuzzy_input_conditioner;

    localparam int H = 16;

    logic clk_0 = 1'b1;
    logic Srst  = 1'b1;

    always #5 clk_0 = ~clk_0;

    fuzzy_input_conditioner_if #(.DATA_W(8)) bus ();

    fuzzy_input_conditioner #(
        .DATA_W      (8),
        .HOLD_CYCLES (H),
        .AVG_LOG2    (2),
        .E_SHIFT     (0),
        .DE_SHIFT    (0)
    ) dut (
        .clk_0 (clk_0),
        .Srst  (Srst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int  m_win[$];
    bit  m_prime;
    int  m_eprev;
    bit  m_lost;
    int  x_e01;
    int  x_e02;
    int  x_se;
    int  x_sde;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int clamp8(input int v, output int sat);
        sat = 1;
        if (v < 0) return 0;
        if (v > 255) return 255;
        sat = 0;
        return v;
    endfunction

    function automatic void model_reset();
        m_win.delete();
        repeat (4) m_win.push_back(0);
        m_prime = 1'b1;
        m_eprev = 0;
        m_lost  = 1'b0;
        x_e01   = 128;
        x_e02   = 128;
        x_se    = 0;
        x_sde   = 0;
    endfunction

    function automatic void model_sample(input int sp, input int m);
        int sum;
        int e;
        int de;
        if (m_prime) begin
            m_win.delete();
            repeat (4) m_win.push_back(m);
        end else begin
            void'(m_win.pop_front());
            m_win.push_back(m);
        end
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        e  = sp - sum / 4;
        de = m_prime ? 0 : e - m_eprev;
        x_e01   = clamp8(e + 128, x_se);
        x_e02   = clamp8(de + 128, x_sde);
        m_eprev = e;
        m_prime = 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk_0);
        Srst = 1'b1;
        #1;
        chk("rst_e01", int'(bus.Entrada_01), 128);
        chk("rst_e02", int'(bus.Entrada_02), 128);
        chk("rst_en", int'(bus.EN_REGRAS), 0);
        chk("rst_busy", int'(bus.busy), 0);
        @(negedge clk_0);
        Srst = 1'b0;
        model_reset();
    endtask

    // pulse_at >= 0 raises sample_req for one cycle that deep into HOLD
    task automatic run_sample(input int sp, input int m, input int pulse_at);
        int en_cnt;
        int dv_cnt;
        int dv_edge;
        int stable;
        @(negedge clk_0);
        bus.sample_req = 1'b1;
        bus.setpoint   = 8'(sp);
        bus.medida     = 8'(m);
        @(posedge clk_0);
        #1;
        bus.sample_req = 1'b0;
        chk("busy_e0", int'(bus.busy), 1);
        chk("en_e0", int'(bus.EN_REGRAS), 0);
        model_sample(sp, m);
        @(posedge clk_0);
        #1;
        chk("en_e1", int'(bus.EN_REGRAS), 0);
        bus.setpoint = 8'($urandom);
        bus.medida   = 8'($urandom);
        @(posedge clk_0);
        #1;
        chk("e01", int'(bus.Entrada_01), x_e01);
        chk("e02", int'(bus.Entrada_02), x_e02);
        chk("sat_e", int'(bus.sat_e), x_se);
        chk("sat_de", int'(bus.sat_de), x_sde);
        en_cnt  = 0;
        dv_cnt  = 0;
        dv_edge = -1;
        stable  = 1;
        for (int k = 2; k <= H + 6; k++) begin
            if (k > 2) begin
                @(posedge clk_0);
                #1;
                bus.sample_req = 1'b0;
            end
            if (bus.EN_REGRAS) en_cnt++;
            if (bus.dado_valido) begin
                dv_cnt++;
                if (dv_edge < 0) dv_edge = k;
            end
            if (int'(bus.Entrada_01) != x_e01 ||
                int'(bus.Entrada_02) != x_e02) stable = 0;
            if (k == H + 2) chk("busy_done", int'(bus.busy), 1);
            if (k == H + 3) chk("busy_end", int'(bus.busy), 0);
            if (pulse_at >= 0 && k == 2 + pulse_at) begin
                @(negedge clk_0);
                bus.sample_req = 1'b1;
                m_lost = 1'b1;
            end
        end
        chk("en_count", en_cnt, H);
        chk("dv_edge", dv_edge, H + 2);
        chk("dv_count", dv_cnt, 1);
        chk("hold_stable", stable, 1);
        chk("lost", int'(bus.req_perdido), int'(m_lost));
    endtask

    initial begin
        bus.sample_req = 1'b0;
        bus.setpoint   = '0;
        bus.medida     = '0;
        Srst = 1'b1;
        #65;
        Srst = 1'b0;
        #1;
        model_reset();
        chk("init_e01", int'(bus.Entrada_01), 128);
        chk("init_e02", int'(bus.Entrada_02), 128);
        chk("init_en", int'(bus.EN_REGRAS), 0);
        chk("init_busy", int'(bus.busy), 0);
        chk("init_dv", int'(bus.dado_valido), 0);
        chk("init_lost", int'(bus.req_perdido), 0);

        run_sample(150, 100, -1);
        chk("t2_e01", int'(bus.Entrada_01), 178);
        chk("t2_e02", int'(bus.Entrada_02), 128);
        run_sample(150, 100, -1);
        chk("t3a_e01", int'(bus.Entrada_01), 178);
        run_sample(150, 60, -1);
        chk("t3b_e01", int'(bus.Entrada_01), 188);
        chk("t3b_e02", int'(bus.Entrada_02), 138);

        do_reset();
        run_sample(255, 0, -1);
        chk("t4a_e01", int'(bus.Entrada_01), 255);
        chk("t4a_sat", int'(bus.sat_e), 1);
        run_sample(0, 0, -1);
        chk("t4b_e02", int'(bus.Entrada_02), 0);
        chk("t4b_sat", int'(bus.sat_de), 1);

        run_sample(100, 120, 5);
        chk("t5_lost", int'(bus.req_perdido), 1);
        run_sample(80, 90, -1);

        @(negedge clk_0);
        bus.sample_req = 1'b1;
        bus.setpoint   = 8'd150;
        bus.medida     = 8'd100;
        @(negedge clk_0);
        bus.sample_req = 1'b0;
        repeat (7) @(negedge clk_0);
        chk("t6_en_pre", int'(bus.EN_REGRAS), 1);
        Srst = 1'b1;
        #1;
        chk("t6_en", int'(bus.EN_REGRAS), 0);
        chk("t6_e01", int'(bus.Entrada_01), 128);
        chk("t6_e02", int'(bus.Entrada_02), 128);
        chk("t6_lost", int'(bus.req_perdido), 0);
        @(negedge clk_0);
        Srst = 1'b0;
        model_reset();
        run_sample(150, 100, -1);
        chk("t6_e01b", int'(bus.Entrada_01), 178);
        chk("t6_e02b", int'(bus.Entrada_02), 128);

        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_0);
            if ($urandom_range(0, 9) == 0) do_reset();
            run_sample(int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)),
                       ($urandom_range(0, 3) == 0) ?
                           int'($urandom_range(0, H - 1)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
